// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out transmitter.
package piso_pkg;

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

   function automatic int cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Beat counter for one word: clear on load/finish, step on each serial beat,
// saturates at WIDTH-1 and flags it as terminal count.
module piso_bit_cnt
   import piso_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr_i,
   input  logic                      en_i,
   output logic [cnt_w(WIDTH)-1:0]   cnt_o,
   output logic                      tc_o
);

   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q != LAST))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready on both sides and
// zero-gap reload when the next word is offered on the last beat.
module piso_tx
   import piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_data,
   output logic             ser_first,
   output logic             ser_last,
   output logic             busy
);

   state_e                  state_q;
   logic [WIDTH-1:0]        sreg_q, sreg_d;
   logic                    vld_q;
   logic [cnt_w(WIDTH)-1:0] cnt;
   logic                    tc;
   logic                    accept, beat;

   assign beat     = vld_q && ser_ready;
   assign in_ready = (state_q == IDLE) || (tc && ser_ready);
   assign accept   = in_valid && in_ready;

   // The outgoing bit always sits at the end of the register, so ser_data is a flop.
   assign sreg_d = LSB_FIRST ? {1'b0, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], 1'b0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  sreg_q  <= in_data;
                  state_q <= SHIFT;
                  vld_q   <= 1'b1;
               end
            end
            SHIFT: begin
               if (beat) begin
                  if (tc && accept) begin
                     sreg_q <= in_data;
                  end else begin
                     sreg_q <= sreg_d;
                     if (tc) begin
                        state_q <= IDLE;
                        vld_q   <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               vld_q   <= 1'b0;
            end
         endcase
      end
   end

   piso_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (accept || (beat && tc)),
      .en_i  (beat),
      .cnt_o (cnt),
      .tc_o  (tc)
   );

   assign ser_valid = vld_q;
   assign busy      = vld_q;
   assign ser_data  = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];
   assign ser_first = vld_q && (cnt == '0);
   assign ser_last  = vld_q && tc;

endmodule

// File: tb/tb_piso_tx.sv
// Four transmitter instances (8/LSB, 8/MSB, 2/LSB, 33/MSB) checked every cycle
// against a word/remaining-bits model of the serial stream.
module tb_piso_tx;

   localparam int W  [4] = '{8, 8, 2, 33};
   localparam bit LF [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  val = '0, rdy = '0;
   logic [63:0] dat [4];
   logic [3:0]  o_inr, o_sv, o_sd, o_sf, o_sl, o_bz;

   int          checks = 0, errors = 0;
   logic [63:0] word [4];
   int          rem [4];
   int          nacc [4], nlast [4], vcnt [4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      piso_tx #(.WIDTH(W[g]), .LSB_FIRST(LF[g])) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (val[g]),
         .in_ready  (o_inr[g]),
         .in_data   (dat[g][W[g]-1:0]),
         .ser_valid (o_sv[g]),
         .ser_ready (rdy[g]),
         .ser_data  (o_sd[g]),
         .ser_first (o_sf[g]),
         .ser_last  (o_sl[g]),
         .busy      (o_bz[g])
      );
   end

   task automatic chk(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, i, obs, exp);
      end
   endtask

   // Model: an accepted word is emitted as W bits in transmit order; rem counts bits still owed.
   task automatic step();
      bit acc [4];
      bit bt  [4];
      bit er;
      int idx;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         er = (rem[i] == 0) || (rem[i] == 1 && rdy[i]);
         chk("in_ready", i, 64'(o_inr[i]), 64'(er));
         chk("ser_valid", i, 64'(o_sv[i]), 64'(rem[i] != 0));
         chk("busy", i, 64'(o_bz[i]), 64'(rem[i] != 0));
         if (rem[i] != 0) begin
            idx = LF[i] ? (W[i] - rem[i]) : (rem[i] - 1);
            chk("ser_data", i, 64'(o_sd[i]), 64'(word[i][idx]));
            chk("ser_first", i, 64'(o_sf[i]), 64'(rem[i] == W[i]));
            chk("ser_last", i, 64'(o_sl[i]), 64'(rem[i] == 1));
         end else begin
            chk("ser_first_idle", i, 64'(o_sf[i]), 64'd0);
            chk("ser_last_idle", i, 64'(o_sl[i]), 64'd0);
         end
         acc[i] = val[i] && er && rst_n;
         bt[i]  = (rem[i] != 0) && rdy[i];
         if (bt[i] && o_sl[i]) nlast[i]++;
         if (acc[i]) nacc[i]++;
         if (o_sv[i]) vcnt[i]++;
      end
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         if (bt[i]) rem[i]--;
         if (acc[i]) begin
            word[i] = dat[i];
            rem[i]  = W[i];
         end
      end
      #1;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         dat[i] = '0; word[i] = '0; rem[i] = 0; nacc[i] = 0; nlast[i] = 0; vcnt[i] = 0;
      end
      rdy = '1;

      // reset held for 3 cycles, then idle
      steps(3);
      rst_n = 1'b1;
      steps(10);

      // single word, LSB first
      dat[0] = 64'hA5; val[0] = 1'b1;
      step();
      val[0] = 1'b0;
      vcnt[0] = 0;
      steps(9);
      chk("single_len", 0, 64'(vcnt[0]), 64'd8);

      // back-to-back, no gap
      dat[0] = 64'hA5; val[0] = 1'b1;
      step();
      dat[0] = 64'h3C;
      vcnt[0] = 0;
      steps(8);
      val[0] = 1'b0;
      steps(10);
      chk("b2b_len", 0, 64'(vcnt[0]), 64'd16);

      // stall on MSB-first instance at beat 3
      dat[1] = 64'hF0; val[1] = 1'b1;
      step();
      val[1] = 1'b0;
      vcnt[1] = 0;
      steps(3);
      rdy[1] = 1'b0;
      steps(4);
      rdy[1] = 1'b1;
      steps(8);
      chk("stall_len", 1, 64'(vcnt[1]), 64'd12);

      // asynchronous reset at beat 5
      dat[0] = 64'hFF; val[0] = 1'b1;
      step();
      val[0] = 1'b0;
      steps(5);
      #2 rst_n = 1'b0;
      #1;
      chk("async_sv", 0, 64'(o_sv[0]), 64'd0);
      chk("async_sd", 0, 64'(o_sd[0]), 64'd0);
      chk("async_busy", 0, 64'(o_bz[0]), 64'd0);
      chk("async_last", 0, 64'(o_sl[0]), 64'd0);
      chk("async_inr", 0, 64'(o_inr[0]), 64'd1);
      for (int i = 0; i < 4; i++) rem[i] = 0;
      steps(2);
      rst_n = 1'b1;
      step();
      dat[0] = 64'h01; val[0] = 1'b1;
      step();
      val[0] = 1'b0;
      steps(10);

      // random sweep on WIDTH=2 and WIDTH=33
      nacc[2] = 0; nacc[3] = 0; nlast[2] = 0; nlast[3] = 0;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 2; i < 4; i++) begin
            val[i] = 1'($urandom_range(0, 1));
            rdy[i] = ($urandom_range(0, 3) != 0);
            dat[i] = val[i] ? {$urandom, $urandom} : 'x;
         end
         step();
      end
      val = '0; rdy = '1;
      steps(40);
      for (int i = 2; i < 4; i++) begin
         chk("words_seen", i, 64'(nacc[i] > 10), 64'd1);
         chk("last_count", i, 64'(nlast[i]), 64'(nacc[i]));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
